instr_fetch: RTL and testbench

//   Fetch stage that reads the combinational instruction memory. Owns the PC,

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 99 +++++++++
 tb/tb_instr_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and IF/ID output register.
// The master side is the fetch stage; the slave side is memory plus decode.
interface instr_fetch_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic            id_ready;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [PC_W-1:0] id_pc;
    logic [PC_W-1:0] id_pc_plus4;
    logic            fault;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fault,
        input  imem_rdata, redirect_valid, redirect_target, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fault,
        output imem_rdata, redirect_valid, redirect_target, id_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and feeds
// decode through a valid/ready IF/ID register. Bad fetch addresses trap sticky.
module instr_fetch #(
    parameter int PC_W     = 32,
    parameter int RESET_PC = 0,
    parameter int MAX_ADDR = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] MAX_ADDR_W = PC_W'(MAX_ADDR);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            id_valid_reg, id_valid_next;
    logic [31:0]     id_instr_reg, id_instr_next;
    logic [PC_W-1:0] id_pc_reg, id_pc_next;
    logic [PC_W-1:0] id_pc_plus4_reg, id_pc_plus4_next;
    logic            fault_reg, fault_next;

    logic            pc_ok;
    logic            slot_free;
    logic [PC_W-1:0] pc_plus4;

    assign pc_ok     = (pc_reg[1:0] == 2'b00) && (pc_reg <= MAX_ADDR_W);
    assign slot_free = !id_valid_reg || bus.id_ready;
    assign pc_plus4  = pc_reg + PC_W'(4);

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        id_valid_next    = id_valid_reg;
        id_instr_next    = id_instr_reg;
        id_pc_next       = id_pc_reg;
        id_pc_plus4_next = id_pc_plus4_reg;
        fault_next       = fault_reg;

        // Redirect beats everything; a word accepted by decode this same cycle
        // still counts as delivered, only the register's valid is dropped.
        if (bus.redirect_valid) begin
            pc_next       = bus.redirect_target;
            id_valid_next = 1'b0;
            fault_next    = 1'b0;
            state_next    = RUN;
        end else begin
            case (state_reg)
                BOOT: state_next = RUN;
                RUN: begin
                    if (slot_free) begin
                        if (pc_ok) begin
                            id_instr_next    = bus.imem_rdata;
                            id_pc_next       = pc_reg;
                            id_pc_plus4_next = pc_plus4;
                            id_valid_next    = 1'b1;
                            pc_next          = pc_plus4;
                        end else begin
                            id_valid_next = 1'b0;
                            fault_next    = 1'b1;
                            state_next    = FAULT;
                        end
                    end
                end
                FAULT:   id_valid_next = 1'b0;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC_W;
            id_valid_reg    <= 1'b0;
            id_instr_reg    <= 32'd0;
            id_pc_reg       <= '0;
            id_pc_plus4_reg <= '0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            id_valid_reg    <= id_valid_next;
            id_instr_reg    <= id_instr_next;
            id_pc_reg       <= id_pc_next;
            id_pc_plus4_reg <= id_pc_plus4_next;
            fault_reg       <= fault_next;
        end
    end

    assign bus.imem_addr   = pc_reg;
    assign bus.id_valid    = id_valid_reg;
    assign bus.id_instr    = id_instr_reg;
    assign bus.id_pc       = id_pc_reg;
    assign bus.id_pc_plus4 = id_pc_plus4_reg;
    assign bus.fault       = fault_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot, stall, redirect, range trap,
// misalignment trap and asynchronous reset mid-stream.
module tb_instr_fetch;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] salt;

    instr_fetch_if #(.PC_W(32)) bus ();

    instr_fetch #(.PC_W(32), .RESET_PC(0), .MAX_ADDR(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory word is a recognisable function of the address; salt perturbs it.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return 32'h1300_0000 ^ a;
    endfunction

    assign bus.imem_rdata = instr_at(bus.imem_addr) ^ {salt, 16'h0000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd1);
        check({tag, "_pc"}, bus.id_pc, pc);
        check({tag, "_instr"}, bus.id_instr, instr_at(pc));
        check({tag, "_plus4"}, bus.id_pc_plus4, pc + 32'd4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        salt = 16'h0000;
        rst_n = 1'b0;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;

        step();
        check("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_instr", bus.id_instr, 32'd0);
        check("rst_pc", bus.id_pc, 32'd0);
        step();

        // Test 1: boot cycle, then one instruction per edge
        rst_n = 1'b1;
        step();
        check("boot_valid", {31'd0, bus.id_valid}, 32'd0);
        step();
        check_id("t1_0", 32'd0);
        step();
        check_id("t1_4", 32'd4);
        step();
        check_id("t1_8", 32'd8);

        // Test 2: stall while memory output changes underneath
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            salt = 16'h00A5 + 16'(i);
            step();
            check_id("t2_hold", 32'd8);
            check("t2_addr", bus.imem_addr, 32'd12);
        end
        salt = 16'h0000;
        bus.id_ready = 1'b1;
        step();
        check_id("t2_12", 32'd12);

        // Test 3: redirect during a stall squashes the held word
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h8C;
        step();
        check("t3_squash", {31'd0, bus.id_valid}, 32'd0);
        check("t3_addr", bus.imem_addr, 32'h8C);
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        step();
        check_id("t3_8c", 32'h8C);
        check("t3_plus4", bus.id_pc_plus4, 32'h90);

        // Test 4: run to the top of the legal range and trap
        for (int a = 32'h90; a <= 256; a += 4) begin
            step();
            check("t4_seq_pc", bus.id_pc, a);
            check("t4_seq_valid", {31'd0, bus.id_valid}, 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_fault", {31'd0, bus.fault}, 32'd1);
            check("t4_valid", {31'd0, bus.id_valid}, 32'd0);
            check("t4_addr", bus.imem_addr, 32'd260);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'd0;
        step();
        check("t4_clr_fault", {31'd0, bus.fault}, 32'd0);
        check("t4_clr_valid", {31'd0, bus.id_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        step();
        check_id("t4_restart", 32'd0);

        // Test 5: misaligned target traps without ever delivering
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h02;
        step();
        check("t5_fault0", {31'd0, bus.fault}, 32'd0);
        check("t5_valid0", {31'd0, bus.id_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t5_fault", {31'd0, bus.fault}, 32'd1);
            check("t5_valid", {31'd0, bus.id_valid}, 32'd0);
            check("t5_addr", bus.imem_addr, 32'h02);
        end

        // Test 6: asynchronous reset mid-stream
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check_id("t6_40", 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'd0, bus.id_valid}, 32'd0);
        check("t6_fault", {31'd0, bus.fault}, 32'd0);
        check("t6_instr", bus.id_instr, 32'd0);
        check("t6_pc", bus.id_pc, 32'd0);
        check("t6_plus4", bus.id_pc_plus4, 32'd0);
        check("t6_addr", bus.imem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_boot", {31'd0, bus.id_valid}, 32'd0);
        step();
        check_id("t6_reboot", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
